// File: rtl/game_pkg.sv
// Shared encodings for the game command sequencer: command kinds, action codes,
// status codes, FSM states and the queued command layout.
package game_pkg;

  typedef enum logic [1:0] {
    KIND_BUY   = 2'd0,
    KIND_PLAY  = 2'd1,
    KIND_START = 2'd2,
    KIND_NOP   = 2'd3
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ACT_KICK  = 3'd0,
    ACT_PUNCH = 3'd1,
    ACT_LEFT  = 3'd2,
    ACT_RIGHT = 3'd3,
    ACT_WAIT  = 3'd4
  } action_e;

  typedef enum logic [2:0] {
    ST_OK         = 3'd0,
    ST_INVALID    = 3'd1,
    ST_CREDIT     = 3'd2,
    ST_OOS        = 3'd3,
    ST_NO_INV     = 3'd4,
    ST_WRONG_DIST = 3'd5,
    ST_TIMEOUT    = 3'd6,
    ST_WIN        = 3'd7
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_PHASE = 2'd1,
    S_ISSUE      = 2'd2,
    S_GAP        = 2'd3
  } seq_state_e;

  typedef struct packed {
    cmd_kind_e  kind;
    logic       player;
    logic [2:0] code;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic status_e buy_status(input logic inv, input logic oos, input logic credit);
    if (inv)         return ST_INVALID;
    else if (oos)    return ST_OOS;
    else if (credit) return ST_CREDIT;
    else             return ST_OK;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_cmd_sequencer_fifo.sv
// Command queue between the host and the sequencer FSM; a push while full is
// dropped even when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/game_cmd_sequencer.sv
// Replays queued host commands to game_top with a one-cycle strobe followed by a
// one-cycle gap, gating on game phase and reporting one status per command.
module game_cmd_sequencer
  import game_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_kind,
  input  logic       cmd_player,
  input  logic [2:0] cmd_code,
  input  logic       phase,
  input  logic [1:0] winner,
  input  logic       purchase_success_p1,
  input  logic       err_invalid_action_p1,
  input  logic       err_credit_p1,
  input  logic       err_out_of_stock_p1,
  input  logic       purchase_success_p2,
  input  logic       err_invalid_action_p2,
  input  logic       err_credit_p2,
  input  logic       err_out_of_stock_p2,
  input  logic       err_no_inventory,
  input  logic       err_wrong_distance,
  output logic       buy_valid_p1,
  output logic       buy_valid_p2,
  output logic [2:0] buy_code_p1,
  output logic [2:0] buy_code_p2,
  output logic       play_valid,
  output logic       turn,
  output logic [2:0] play_action,
  output logic       start_round,
  output logic       busy,
  output logic       done_valid,
  output logic [2:0] done_status,
  output logic [7:0] ok_count,
  output logic [7:0] err_count
);
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  seq_state_e       state;
  cmd_t             cmd_r, head;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, pop;
  logic [3:0]       wait_cnt;
  status_e          pend_status, issue_status, gap_status, fin_status;
  logic             phase_ok, timeout_hit, fin;
  logic             unused_flags;

  assign unused_flags = purchase_success_p1 ^ purchase_success_p2;

  assign pop       = (state == S_IDLE) && !fifo_empty;
  assign head      = cmd_t'(fifo_rdata);
  assign cmd_ready = !fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;

  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata ({cmd_kind, cmd_player, cmd_code}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    phase_ok = phase;
    case (cmd_r.kind)
      KIND_PLAY: phase_ok = !phase;
      KIND_NOP:  phase_ok = 1'b1;
      default:   phase_ok = phase;
    endcase
  end

  // Response flags are live only while the strobe is up, so they are folded into a status here.
  always_comb begin
    issue_status = ST_OK;
    case (cmd_r.kind)
      KIND_BUY: begin
        if (cmd_r.player)
          issue_status = buy_status(err_invalid_action_p2, err_out_of_stock_p2, err_credit_p2);
        else
          issue_status = buy_status(err_invalid_action_p1, err_out_of_stock_p1, err_credit_p1);
      end
      KIND_PLAY: begin
        if (err_no_inventory)        issue_status = ST_NO_INV;
        else if (err_wrong_distance) issue_status = ST_WRONG_DIST;
      end
      default: issue_status = ST_OK;
    endcase
  end

  assign gap_status  = (cmd_r.kind == KIND_PLAY && pend_status == ST_OK && winner != 2'd0)
                       ? ST_WIN : pend_status;
  assign timeout_hit = (state == S_WAIT_PHASE) && (cmd_r.kind != KIND_NOP) && !phase_ok
                       && (wait_cnt == TO_LAST);
  assign fin         = (state == S_GAP) || timeout_hit;
  assign fin_status  = (state == S_GAP) ? gap_status : ST_TIMEOUT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cmd_r        <= '0;
      wait_cnt     <= '0;
      pend_status  <= ST_OK;
      buy_valid_p1 <= 1'b0;
      buy_valid_p2 <= 1'b0;
      buy_code_p1  <= '0;
      buy_code_p2  <= '0;
      play_valid   <= 1'b0;
      turn         <= 1'b0;
      play_action  <= '0;
      start_round  <= 1'b0;
      done_valid   <= 1'b0;
      done_status  <= '0;
      ok_count     <= '0;
      err_count    <= '0;
    end else begin
      buy_valid_p1 <= 1'b0;
      buy_valid_p2 <= 1'b0;
      play_valid   <= 1'b0;
      start_round  <= 1'b0;
      done_valid   <= fin;
      if (fin) begin
        done_status <= fin_status;
        if (fin_status == ST_OK)       ok_count  <= sat_inc(ok_count);
        else if (fin_status != ST_WIN) err_count <= sat_inc(err_count);
      end
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cmd_r    <= head;
            wait_cnt <= '0;
            state    <= S_WAIT_PHASE;
          end
        end
        S_WAIT_PHASE: begin
          if (cmd_r.kind == KIND_NOP) begin
            pend_status <= ST_OK;
            state       <= S_GAP;
          end else if (phase_ok) begin
            state <= S_ISSUE;
            case (cmd_r.kind)
              KIND_BUY: begin
                if (cmd_r.player) begin
                  buy_valid_p2 <= 1'b1;
                  buy_code_p2  <= cmd_r.code;
                end else begin
                  buy_valid_p1 <= 1'b1;
                  buy_code_p1  <= cmd_r.code;
                end
              end
              KIND_PLAY: begin
                play_valid  <= 1'b1;
                turn        <= cmd_r.player;
                play_action <= cmd_r.code;
              end
              default: start_round <= 1'b1;
            endcase
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_ISSUE: begin
          pend_status <= issue_status;
          state       <= S_GAP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_cmd_sequencer.sv
// Directed bench for game_cmd_sequencer with a small combinational game model.
module tb_game_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, to_sel = 1'b0, cmd_valid_to;
  logic [1:0] cmd_kind = '0;
  logic       cmd_player = 1'b0;
  logic [2:0] cmd_code = '0;
  logic       phase_drv = 1'b1, phase;
  logic [1:0] winner;
  logic       inv_en = 0, cred_en = 0, noinv_en = 0, wd_en = 0, win_en = 0;
  logic [3:0] stock_init = 4'd15;

  logic ps_p1, eia_p1, ecr_p1, eos_p1, ps_p2, eia_p2, ecr_p2, eos_p2, e_noinv, e_wd;

  logic       cmd_ready, buy_valid_p1, buy_valid_p2, play_valid, turn, start_round, busy, done_valid;
  logic [2:0] buy_code_p1, buy_code_p2, play_action, done_status;
  logic [7:0] ok_count, err_count;

  logic       cmd_ready_t, buy_valid_p1_t, buy_valid_p2_t, play_valid_t, turn_t, start_round_t, busy_t, done_valid_t;
  logic [2:0] buy_code_p1_t, buy_code_p2_t, play_action_t, done_status_t;
  logic [7:0] ok_count_t, err_count_t;

  // Game model: START moves the game to PLAY phase, a PLAY may win, P1 has finite stock.
  logic       start_seen;
  logic [1:0] win_r;
  logic [3:0] stock_p1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_seen <= 1'b0;
      win_r      <= 2'd0;
      stock_p1   <= stock_init;
    end else begin
      if (start_round) start_seen <= 1'b1;
      if (play_valid && win_en) win_r <= turn ? 2'd2 : 2'd1;
      if (buy_valid_p1 && stock_p1 != 4'd0) stock_p1 <= stock_p1 - 4'd1;
    end
  end
  assign phase        = start_seen ? 1'b0 : phase_drv;
  assign winner       = win_r;
  assign eia_p1       = buy_valid_p1 & inv_en;
  assign ecr_p1       = buy_valid_p1 & cred_en;
  assign eos_p1       = buy_valid_p1 & (stock_p1 == 4'd0);
  assign ps_p1        = buy_valid_p1 & ~(eia_p1 | ecr_p1 | eos_p1);
  assign eia_p2       = 1'b0;
  assign ecr_p2       = 1'b0;
  assign eos_p2       = 1'b0;
  assign ps_p2        = buy_valid_p2;
  assign e_noinv      = play_valid & noinv_en;
  assign e_wd         = play_valid & wd_en;
  assign cmd_valid_to = cmd_valid & to_sel;

  game_cmd_sequencer #(.DEPTH(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_player(cmd_player), .cmd_code(cmd_code),
    .phase(phase), .winner(winner),
    .purchase_success_p1(ps_p1), .err_invalid_action_p1(eia_p1), .err_credit_p1(ecr_p1), .err_out_of_stock_p1(eos_p1),
    .purchase_success_p2(ps_p2), .err_invalid_action_p2(eia_p2), .err_credit_p2(ecr_p2), .err_out_of_stock_p2(eos_p2),
    .err_no_inventory(e_noinv), .err_wrong_distance(e_wd),
    .buy_valid_p1(buy_valid_p1), .buy_valid_p2(buy_valid_p2), .buy_code_p1(buy_code_p1), .buy_code_p2(buy_code_p2),
    .play_valid(play_valid), .turn(turn), .play_action(play_action), .start_round(start_round),
    .busy(busy), .done_valid(done_valid), .done_status(done_status), .ok_count(ok_count), .err_count(err_count)
  );

  game_cmd_sequencer #(.DEPTH(16), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_to), .cmd_ready(cmd_ready_t),
    .cmd_kind(cmd_kind), .cmd_player(cmd_player), .cmd_code(cmd_code),
    .phase(phase), .winner(winner),
    .purchase_success_p1(1'b0), .err_invalid_action_p1(1'b0), .err_credit_p1(1'b0), .err_out_of_stock_p1(1'b0),
    .purchase_success_p2(1'b0), .err_invalid_action_p2(1'b0), .err_credit_p2(1'b0), .err_out_of_stock_p2(1'b0),
    .err_no_inventory(1'b0), .err_wrong_distance(1'b0),
    .buy_valid_p1(buy_valid_p1_t), .buy_valid_p2(buy_valid_p2_t), .buy_code_p1(buy_code_p1_t), .buy_code_p2(buy_code_p2_t),
    .play_valid(play_valid_t), .turn(turn_t), .play_action(play_action_t), .start_round(start_round_t),
    .busy(busy_t), .done_valid(done_valid_t), .done_status(done_status_t), .ok_count(ok_count_t), .err_count(err_count_t)
  );

  // Event log of the main instance, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         strobe_n = 0, done_n = 0, overlap_cnt = 0, adjacent_cnt = 0, nstb;
  int         strobe_cyc [256];
  logic [1:0] strobe_kind [256];
  logic [2:0] strobe_code [256];
  logic       strobe_turn [256];
  int         done_cyc [256];
  logic [2:0] done_st [256];
  logic       prev_any = 1'b0;

  always @(negedge clk) begin
    nstb = int'(buy_valid_p1) + int'(buy_valid_p2) + int'(play_valid) + int'(start_round);
    if (nstb > 1) overlap_cnt++;
    if (nstb > 0 && prev_any) adjacent_cnt++;
    prev_any = (nstb > 0);
    if (nstb > 0 && strobe_n < 256) begin
      strobe_cyc[strobe_n]  = cyc;
      strobe_kind[strobe_n] = buy_valid_p1 ? 2'd0 : buy_valid_p2 ? 2'd1 : play_valid ? 2'd2 : 2'd3;
      strobe_code[strobe_n] = buy_valid_p1 ? buy_code_p1 : buy_valid_p2 ? buy_code_p2 : play_action;
      strobe_turn[strobe_n] = turn;
      strobe_n++;
    end
    if (done_valid && done_n < 256) begin
      done_cyc[done_n] = cyc;
      done_st[done_n]  = done_status;
      done_n++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] stock);
    stock_init = stock;
    inv_en = 0; cred_en = 0; noinv_en = 0; wd_en = 0; win_en = 0; to_sel = 0;
    phase_drv = 1'b1; cmd_valid = 1'b0;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic push(input logic [1:0] kind, input logic player, input logic [2:0] code);
    cmd_kind = kind; cmd_player = player; cmd_code = code; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    checks++; if ({buy_valid_p1, buy_valid_p2, buy_code_p1, buy_code_p2, play_valid, turn, play_action,
                   start_round, done_valid, done_status} !== 21'd0) begin
      errors++; $display("FAIL reset_outputs got nonzero strobes/codes/done, expected all 0"); end
    checks++; if ({ok_count, err_count} !== 16'd0) begin
      errors++; $display("FAIL reset_counters got ok=%0d err=%0d expected 0 0", ok_count, err_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
  endtask

  task automatic test_invalid_buy;
    int s0, d0, c0;
    do_reset(4'd15);
    inv_en = 1'b1; cred_en = 1'b1;
    s0 = strobe_n; d0 = done_n; c0 = cyc;
    push(2'd0, 1'b0, 3'd5);
    repeat (10) tick;
    checks++; if (strobe_n - s0 !== 1) begin errors++; $display("FAIL inv_strobe_count got %0d expected 1", strobe_n - s0); end
    checks++; if (strobe_kind[s0] !== 2'd0) begin errors++; $display("FAIL inv_strobe_kind got %0d expected 0", strobe_kind[s0]); end
    checks++; if (strobe_code[s0] !== 3'd5) begin errors++; $display("FAIL inv_buy_code got %0d expected 5", strobe_code[s0]); end
    checks++; if (strobe_cyc[s0] - c0 !== 3) begin errors++; $display("FAIL inv_strobe_latency got %0d expected 3", strobe_cyc[s0] - c0); end
    checks++; if (done_n - d0 !== 1) begin errors++; $display("FAIL inv_done_count got %0d expected 1", done_n - d0); end
    checks++; if (done_cyc[d0] - c0 !== 5) begin errors++; $display("FAIL inv_done_latency got %0d expected 5", done_cyc[d0] - c0); end
    checks++; if (done_st[d0] !== 3'd1) begin errors++; $display("FAIL inv_status got %0d expected 1", done_st[d0]); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL inv_err_count got %0d expected 1", err_count); end
    checks++; if (ok_count !== 8'd0) begin errors++; $display("FAIL inv_ok_count got %0d expected 0", ok_count); end
  endtask

  task automatic test_stock_drain;
    int s0, d0;
    logic [2:0] exp_st [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
    do_reset(4'd5);
    s0 = strobe_n; d0 = done_n;
    for (int k = 0; k < 6; k++) push(2'd0, 1'b0, 3'd4);
    repeat (30) tick;
    checks++; if (done_n - d0 !== 6) begin errors++; $display("FAIL drain_done_count got %0d expected 6", done_n - d0); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (done_st[d0+k] !== exp_st[k]) begin
        errors++; $display("FAIL drain_status[%0d] got %0d expected %0d", k, done_st[d0+k], exp_st[k]); end
    end
    for (int k = 1; k < 6; k++) begin
      checks++; if (strobe_cyc[s0+k] - strobe_cyc[s0+k-1] !== 4) begin
        errors++; $display("FAIL drain_spacing[%0d] got %0d expected 4", k, strobe_cyc[s0+k] - strobe_cyc[s0+k-1]); end
    end
    checks++; if (ok_count !== 8'd5) begin errors++; $display("FAIL drain_ok_count got %0d expected 5", ok_count); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL drain_err_count got %0d expected 1", err_count); end
  endtask

  task automatic test_timeout;
    int pv = 0, dt = -1, dd = -1;
    logic [2:0] st_t = '0, st = '0;
    do_reset(4'd15);
    phase_drv = 1'b1; to_sel = 1'b1;
    push(2'd1, 1'b0, 3'd2);
    to_sel = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (play_valid || play_valid_t) pv++;
      if (done_valid_t && dt < 0) begin dt = i; st_t = done_status_t; end
      if (done_valid && dd < 0) begin dd = i; st = done_status; end
      tick;
    end
    checks++; if (pv !== 0) begin errors++; $display("FAIL to_play_strobes got %0d expected 0", pv); end
    checks++; if (dt !== 10) begin errors++; $display("FAIL to8_done_cycle got %0d expected 10", dt); end
    checks++; if (st_t !== 3'd6) begin errors++; $display("FAIL to8_status got %0d expected 6", st_t); end
    checks++; if (err_count_t !== 8'd1) begin errors++; $display("FAIL to8_err_count got %0d expected 1", err_count_t); end
    checks++; if (dd !== 17) begin errors++; $display("FAIL to15_done_cycle got %0d expected 17", dd); end
    checks++; if (st !== 3'd6) begin errors++; $display("FAIL to15_status got %0d expected 6", st); end
  endtask

  task automatic test_win;
    int s0, d0;
    do_reset(4'd15);
    win_en = 1'b1;
    s0 = strobe_n; d0 = done_n;
    push(2'd2, 1'b0, 3'd0);
    push(2'd1, 1'b1, 3'd1);
    repeat (16) tick;
    checks++; if (strobe_n - s0 !== 2) begin errors++; $display("FAIL win_strobe_count got %0d expected 2", strobe_n - s0); end
    checks++; if (strobe_kind[s0] !== 2'd3) begin errors++; $display("FAIL win_start_kind got %0d expected 3", strobe_kind[s0]); end
    checks++; if (strobe_kind[s0+1] !== 2'd2) begin errors++; $display("FAIL win_play_kind got %0d expected 2", strobe_kind[s0+1]); end
    checks++; if (strobe_turn[s0+1] !== 1'b1) begin errors++; $display("FAIL win_turn got %0d expected 1", strobe_turn[s0+1]); end
    checks++; if (strobe_code[s0+1] !== 3'd1) begin errors++; $display("FAIL win_action got %0d expected 1", strobe_code[s0+1]); end
    checks++; if (done_st[d0] !== 3'd0) begin errors++; $display("FAIL win_start_status got %0d expected 0", done_st[d0]); end
    checks++; if (done_st[d0+1] !== 3'd7) begin errors++; $display("FAIL win_play_status got %0d expected 7", done_st[d0+1]); end
    checks++; if (ok_count !== 8'd1) begin errors++; $display("FAIL win_ok_count got %0d expected 1", ok_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL win_err_count got %0d expected 0", err_count); end
  endtask

  task automatic test_play_errors;
    int d0;
    do_reset(4'd15);
    phase_drv = 1'b0; noinv_en = 1'b1; wd_en = 1'b1;
    d0 = done_n;
    push(2'd1, 1'b0, 3'd0);
    repeat (8) tick;
    noinv_en = 1'b0;
    push(2'd1, 1'b0, 3'd0);
    repeat (8) tick;
    checks++; if (done_st[d0] !== 3'd4) begin errors++; $display("FAIL play_noinv_status got %0d expected 4", done_st[d0]); end
    checks++; if (done_st[d0+1] !== 3'd5) begin errors++; $display("FAIL play_wd_status got %0d expected 5", done_st[d0+1]); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL play_err_count got %0d expected 2", err_count); end
  endtask

  task automatic test_fifo_full;
    int d0, d1, bad = 0;
    do_reset(4'd15);
    phase_drv = 1'b0;
    d0 = done_n;
    push(2'd0, 1'b1, 3'd0);
    for (int k = 1; k <= 17; k++) begin
      if (k == 16) begin
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_before_16th got %b expected 1", cmd_ready); end
      end
      if (k == 17) begin
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after_16th got %b expected 0", cmd_ready); end
      end
      push(2'd0, 1'b1, 3'(k));
    end
    checks++; if (done_n - d0 !== 1) begin errors++; $display("FAIL full_head_done got %0d expected 1", done_n - d0); end
    checks++; if (done_st[d0] !== 3'd6) begin errors++; $display("FAIL full_head_status got %0d expected 6", done_st[d0]); end
    d1 = done_n;
    phase_drv = 1'b1;
    repeat (90) tick;
    for (int k = d1; k < done_n; k++) if (done_st[k] !== 3'd0) bad++;
    checks++; if (done_n - d1 !== 16) begin errors++; $display("FAIL full_drain_count got %0d expected 16", done_n - d1); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_drain_bad_status got %0d expected 0", bad); end
    checks++; if (ok_count !== 8'd16) begin errors++; $display("FAIL full_ok_count got %0d expected 16", ok_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_issue;
    int d0, seen = 0;
    do_reset(4'd15);
    push(2'd0, 1'b0, 3'd3);
    for (int i = 0; i < 8 && seen == 0; i++) begin
      if (buy_valid_p1) seen = 1;
      else tick;
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL rst_strobe_seen got %0d expected 1", seen); end
    d0 = done_n;
    rst_n = 1'b0;
    #1;
    checks++; if (buy_valid_p1 !== 1'b0) begin errors++; $display("FAIL rst_strobe_async got %b expected 0", buy_valid_p1); end
    checks++; if ({ok_count, err_count} !== 16'd0) begin
      errors++; $display("FAIL rst_counters got ok=%0d err=%0d expected 0 0", ok_count, err_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b expected 1", cmd_ready); end
    @(negedge clk);
    tick;
    rst_n = 1'b1;
    repeat (10) tick;
    checks++; if (done_n - d0 !== 0) begin errors++; $display("FAIL rst_no_done got %0d expected 0", done_n - d0); end
  endtask

  task automatic test_exclusive;
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL strobe_overlap got %0d expected 0", overlap_cnt); end
    checks++; if (adjacent_cnt !== 0) begin errors++; $display("FAIL strobe_adjacent got %0d expected 0", adjacent_cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_invalid_buy;
    test_stock_drain;
    test_timeout;
    test_win;
    test_play_errors;
    test_fifo_full;
    test_reset_mid_issue;
    test_exclusive;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_cmd_sequencer.md
# game_cmd_sequencer

Command-issuing front end for `game_top`; it drives the game's input interface in place of a bench or a human player. A host pushes BUY, PLAY and START commands into an internal FIFO. The sequencer replays them to `game_top` with the one-cycle-valid, one-cycle-gap handshake the game requires. It gates each command on the game phase, samples the game's response flags, and reports one status code per command.

## Interface
Parameters:
- DEPTH, 16: command FIFO entries (power of two, ≥2)
- TIMEOUT, 15: maximum cycles to wait for the phase a command needs (4-bit counter)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  host command strobe
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_kind  in  2  command kind: 0 BUY, 1 PLAY, 2 START, 3 NOP
- cmd_player  in  1  0 = P1, 1 = P2
- cmd_code  in  3  shop code or play action
- phase  in  1  from game: 1 = SHOP, 0 = PLAY
- winner  in  2  from game: 0 none, 1 P1, 2 P2
- purchase_success_p1, err_invalid_action_p1, err_credit_p1, err_out_of_stock_p1  in  1 each  P1 shop response flags
- purchase_success_p2, err_invalid_action_p2, err_credit_p2, err_out_of_stock_p2  in  1 each  P2 shop response flags
- err_no_inventory, err_wrong_distance  in  1 each  play response flags
- buy_valid_p1, buy_valid_p2  out  1 each  registered buy strobes
- buy_code_p1, buy_code_p2  out  3 each  registered buy codes
- play_valid  out  1  registered play strobe
- turn  out  1  registered player select for play
- play_action  out  3  registered play action
- start_round  out  1  registered start strobe
- busy  out  1  state ≠ IDLE or FIFO not empty
- done_valid  out  1  one-cycle pulse: a command completed
- done_status  out  3  status of the completed command
- ok_count  out  8  commands that completed with status 0; saturates at 255
- err_count  out  8  commands that completed with status 1–6; saturates at 255

## Operation
- State machine: IDLE → WAIT_PHASE → ISSUE → GAP → IDLE.
- IDLE: if the FIFO is not empty, pop the head into the command register and go to WAIT_PHASE.
- WAIT_PHASE, phase requirement:
  - BUY needs phase=1.
  - PLAY needs phase=0.
  - START needs phase=1.
  - NOP needs nothing and skips straight to GAP with status 0.
- WAIT_PHASE, timing: when the requirement holds, go to ISSUE; otherwise increment a wait counter. When the counter reaches TIMEOUT, emit status 6 and return to IDLE without issuing.
- ISSUE: drive exactly one strobe high for exactly one cycle, together with its code/turn:
  - `buy_valid_p1` or `buy_valid_p2` per `cmd_player` for BUY.
  - `play_valid` for PLAY.
  - `start_round` for START.
- Response sampling: the response flags are combinational from the game during the ISSUE cycle. They are captured on the clock edge that ends ISSUE.
- GAP: all strobes are low for one cycle. At the end of GAP, `winner` is sampled for PLAY commands. The sequencer then emits `done_valid` with `done_status` and returns to IDLE.
- Status codes: 0 OK, 1 INVALID, 2 CREDIT, 3 OUT_OF_STOCK, 4 NO_INVENTORY, 5 WRONG_DISTANCE, 6 TIMEOUT, 7 WIN.
- BUY status priority: INVALID > OUT_OF_STOCK > CREDIT > OK.
- PLAY status priority: NO_INVENTORY > WRONG_DISTANCE > WIN (winner≠0 at end of GAP) > OK.
- START always reports OK.
- A BUY that raises no flag, and no `purchase_success`, reports OK.
- Counters:
  - status 0 increments `ok_count`.
  - status 1–6 increments `err_count`.
  - status 7 increments neither.
  - Both counters saturate at 255.
- FIFO rules:
  - A push is accepted only when `cmd_ready` is high.
  - A push while full is dropped, even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
  - Count width is clog2(DEPTH)+1.

## Timing
- Reset values:
  - All strobes, codes, `turn`, `done_valid` and `done_status` = 0.
  - Both counters = 0.
  - FIFO empty; state IDLE.
  - `cmd_ready` = 1; `busy` = 0.
- Asserting `rst_n` low mid-operation clears all strobes immediately. Any in-flight command is lost and no `done_valid` is produced for it.
- Minimum latency for a command already in phase:
  - Push at cycle 0 is visible in the FIFO at cycle 1.
  - IDLE pops at cycle 1; WAIT_PHASE at cycle 2; strobe at cycle 3; GAP at cycle 4.
  - `done_valid` at cycle 5.
- Back-to-back commands issue one strobe every 4 cycles. Successive strobes are never adjacent.
- Output ownership:
  - Only one of `buy_valid_p1`, `buy_valid_p2`, `play_valid`, `start_round` is ever high in any cycle.
  - Codes and `turn` are held stable for the whole strobe cycle.

## Structure
- Package `game_pkg` holds:
  - The cmd_kind encodings.
  - The buy/play action codes (0 Kick, 1 Punch, 2 Left, 3 Right, 4 Wait).
  - The status codes and the state enum.
- Sub-module `cmd_fifo`: synchronous FIFO of width 6 (kind, player, code), DEPTH entries, with full/empty outputs and asynchronous active-low reset.

## Test plan
- Invalid buy:
  - Stimulus: push BUY P1 code 5 with phase=1; the game model raises `err_invalid_action_p1` during the strobe.
  - Required: `buy_valid_p1` high exactly 1 cycle with `buy_code_p1`=5; `done_status`=1; `err_count`=1.
- Stock drain:
  - Stimulus: push 6×BUY P1 code 4; the model raises `err_out_of_stock_p1` on the 6th.
  - Required: statuses 0,0,0,0,0,3; `ok_count`=5; strobes spaced 4 cycles apart.
- Phase timeout:
  - Stimulus: TIMEOUT=8; push PLAY P1 code 2 with phase held at 1.
  - Required: no `play_valid` for 8 cycles, then `done_status`=6.
- Win:
  - Stimulus: push START, then PLAY P2 code 1; the model switches phase to 0 after start and sets winner=2 after the punch.
  - Required: `start_round` pulses once; `turn`=1 and `play_action`=1 during the strobe; final status 7; counters unchanged by the WIN.
- FIFO full:
  - Stimulus: stall the sequencer by holding phase=0 with BUYs queued; push 17 commands.
  - Required: `cmd_ready` low after the 16th accepted push; the 17th is dropped; after the stall clears, exactly 16 `done_valid` pulses.
- Reset mid-issue:
  - Stimulus: drive `rst_n` low in the ISSUE cycle.
  - Required: `buy_valid_p1` falls without waiting for a clock edge; counters 0; `cmd_ready`=1; no `done_valid`.
